// File: rtl/biquad_scheduler.sv
// Time-multiplexes NUM_BANDS biquad bands onto one external double_biquad datapath.
// Each accepted sample is run through every band in order: ISSUE -> WAIT -> WRITE -> ADVANCE.
module biquad_scheduler #(
  parameter int NUM_BANDS = 16,
  parameter int TIMEOUT   = 64   // must be >= 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic signed [23:0]           sample_in,
  input  logic                         sample_valid_in,
  output logic                         ready_out,
  output logic [$clog2(NUM_BANDS)-1:0] coeff_sel_out,
  output logic signed [23:0]           bq_x_n_out,
  output logic signed [23:0]           bq_x_n1_out,
  output logic signed [23:0]           bq_x_n2_out,
  output logic signed [23:0]           bq_y_n1_out,
  output logic signed [23:0]           bq_y_n2_out,
  output logic                         bq_start_out,
  input  logic                         bq_done_in,
  input  logic signed [23:0]           bq_y_in,
  output logic signed [23:0]           band_out,
  output logic [$clog2(NUM_BANDS)-1:0] band_idx_out,
  output logic                         band_valid_out,
  output logic                         frame_done_out,
  output logic                         overrun_out,
  output logic                         timeout_out
);

  localparam int DATA_W = 24;
  localparam int BW     = $clog2(NUM_BANDS);
  localparam int TW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, ADVANCE} state_t;

  state_t                    state, state_nxt;
  logic [BW-1:0]             band;
  logic [TW-1:0]             tcnt;
  logic signed [DATA_W-1:0]  x_n, x_n1, x_n2, result;
  logic signed [DATA_W-1:0]  y_n1_mem [NUM_BANDS];
  logic signed [DATA_W-1:0]  y_n2_mem [NUM_BANDS];
  logic                      last_band;
  logic                      wait_expired;

  assign last_band = (band == BW'(NUM_BANDS - 1));
  // The ISSUE cycle counts toward the budget, so expiry lands TIMEOUT cycles after the start pulse.
  assign wait_expired = (state == WAIT) && !bq_done_in && (tcnt == TW'(TIMEOUT - 2));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid_in) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bq_done_in || wait_expired) state_nxt = WRITE;
      WRITE:   state_nxt = ADVANCE;
      ADVANCE: state_nxt = last_band ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, band counter, wait counter, sticky flags
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      band        <= '0;
      tcnt        <= '0;
      overrun_out <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sample_valid_in)
        band <= '0;
      else if (state == ADVANCE && !last_band)
        band <= band + BW'(1);
      if (state == ISSUE)
        tcnt <= '0;
      else if (state == WAIT)
        tcnt <= tcnt + TW'(1);
      if (sample_valid_in && state != IDLE)
        overrun_out <= 1'b1;
      if (wait_expired)
        timeout_out <= 1'b1;
    end
  end

  // Data: shared x history, captured result, per-band y history
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_n    <= '0;
      x_n1   <= '0;
      x_n2   <= '0;
      result <= '0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        y_n1_mem[i] <= '0;
        y_n2_mem[i] <= '0;
      end
    end else begin
      if (state == IDLE && sample_valid_in)
        x_n <= sample_in;
      if (state == WAIT && bq_done_in)
        result <= bq_y_in;
      else if (wait_expired)
        result <= '0;
      if (state == WRITE) begin
        y_n2_mem[band] <= y_n1_mem[band];
        y_n1_mem[band] <= result;
      end
      if (state == ADVANCE && last_band) begin
        x_n2 <= x_n1;
        x_n1 <= x_n;
      end
    end
  end

  // Operands come straight from registers that only move outside ISSUE/WAIT, so they hold steady.
  assign ready_out      = (state == IDLE);
  assign coeff_sel_out  = band;
  assign bq_x_n_out     = x_n;
  assign bq_x_n1_out    = x_n1;
  assign bq_x_n2_out    = x_n2;
  assign bq_y_n1_out    = y_n1_mem[band];
  assign bq_y_n2_out    = y_n2_mem[band];
  assign bq_start_out   = (state == ISSUE);
  assign band_out       = result;
  assign band_idx_out   = band;
  assign band_valid_out = (state == WRITE);
  assign frame_done_out = (state == ADVANCE) && last_band;

endmodule

// File: tb/tb_biquad_scheduler.sv
// Directed bench for biquad_scheduler with a behavioural datapath that answers y = band + 1.
module tb_biquad_scheduler;

  localparam int NB = 4;
  localparam int TO = 8;

  logic               clk_in, rst_in;
  logic signed [23:0] sample_in;
  logic               sample_valid_in, ready_out;
  logic [1:0]         coeff_sel_out, band_idx_out;
  logic signed [23:0] bq_x_n_out, bq_x_n1_out, bq_x_n2_out, bq_y_n1_out, bq_y_n2_out;
  logic               bq_start_out, bq_done_in;
  logic signed [23:0] bq_y_in, band_out;
  logic               band_valid_out, frame_done_out, overrun_out, timeout_out;

  logic               model_done, manual_done;
  logic signed [23:0] model_y, manual_y;
  assign bq_done_in = model_done | manual_done;
  assign bq_y_in    = manual_done ? manual_y : model_y;

  biquad_scheduler #(.NUM_BANDS(NB), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .ready_out(ready_out), .coeff_sel_out(coeff_sel_out), .bq_x_n_out(bq_x_n_out),
    .bq_x_n1_out(bq_x_n1_out), .bq_x_n2_out(bq_x_n2_out), .bq_y_n1_out(bq_y_n1_out),
    .bq_y_n2_out(bq_y_n2_out), .bq_start_out(bq_start_out), .bq_done_in(bq_done_in),
    .bq_y_in(bq_y_in), .band_out(band_out), .band_idx_out(band_idx_out),
    .band_valid_out(band_valid_out), .frame_done_out(frame_done_out),
    .overrun_out(overrun_out), .timeout_out(timeout_out));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  // Datapath model: done 'model_delay' cycles after the start pulse, never for skip_band.
  int model_delay = 2;
  int skip_band   = -1;
  int pend        = 0;
  logic signed [23:0] pend_y;
  always @(negedge clk_in) begin
    model_done = 1'b0;
    if (!rst_in) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          model_done = 1'b1;
          model_y    = pend_y;
        end
      end
      if (bq_start_out && int'(coeff_sel_out) != skip_band) begin
        pend   = model_delay;
        pend_y = 24'(int'(coeff_sel_out) + 1);
      end
    end
  end

  // Monitor: operand capture per band, output stream, operand stability while busy
  int q_idx[$];
  int q_val[$];
  int frames = 0, start_cnt = 0, stab_err = 0, done_cyc = 0, to_cyc = 0, last_sel = 0, mb = 0;
  bit busy = 0, to_seen = 0;
  int start_cyc [NB];
  int cap_xn [NB];
  int cap_x1 [NB];
  int cap_x2 [NB];
  int cap_y1 [NB];
  int cap_y2 [NB];
  logic [1:0]         cur_sel;
  logic signed [23:0] cur_xn, cur_x1, cur_x2, cur_y1, cur_y2;
  always @(negedge clk_in) begin
    if (!rst_in) busy = 0;
    else begin
      if (bq_start_out) begin
        mb = int'(coeff_sel_out);
        start_cnt++;
        last_sel      = mb;
        start_cyc[mb] = cyc;
        cap_xn[mb] = int'(bq_x_n_out);  cap_x1[mb] = int'(bq_x_n1_out);
        cap_x2[mb] = int'(bq_x_n2_out); cap_y1[mb] = int'(bq_y_n1_out);
        cap_y2[mb] = int'(bq_y_n2_out);
        cur_sel = coeff_sel_out; cur_xn = bq_x_n_out; cur_x1 = bq_x_n1_out;
        cur_x2 = bq_x_n2_out; cur_y1 = bq_y_n1_out; cur_y2 = bq_y_n2_out;
        busy = 1;
      end else if (busy && (coeff_sel_out != cur_sel || bq_x_n_out != cur_xn ||
                            bq_x_n1_out != cur_x1 || bq_x_n2_out != cur_x2 ||
                            bq_y_n1_out != cur_y1 || bq_y_n2_out != cur_y2)) begin
        stab_err++;
      end
      if (band_valid_out) begin
        q_idx.push_back(int'(band_idx_out));
        q_val.push_back(int'(band_out));
        busy = 0;
      end
      if (frame_done_out) begin
        frames++;
        done_cyc = cyc;
      end
      if (timeout_out && !to_seen) begin
        to_seen = 1;
        to_cyc  = cyc;
      end
    end
  end

  // Waits for ready, strobes one sample, then waits (bounded) for its frame_done.
  task automatic do_frame(input logic signed [23:0] s, output int acc);
    int n = 0;
    int f0;
    while (!ready_out && n < 100) begin tick(); n++; end
    f0 = frames;
    sample_in = s; sample_valid_in = 1'b1; acc = cyc;
    tick();
    sample_valid_in = 1'b0;
    n = 0;
    while (frames == f0 && n < 300) begin tick(); n++; end
    if (frames == f0) chk("frame_done_wait", frames, f0 + 1);
    tick(); tick();
  endtask

  task automatic chk_stream(input string tag, input int skip);
    chk({tag, "_count"}, q_idx.size(), NB);
    for (int i = 0; i < NB; i++) begin
      if (i < q_idx.size()) begin
        chk({tag, "_idx"}, q_idx[i], i);
        chk({tag, "_val"}, q_val[i], (i == skip) ? 0 : i + 1);
      end
    end
  endtask

  typedef struct {
    logic signed [23:0] smp;
    int delay, skip;
    int x1, x2, b1y1, b1y2, b2y1, b2y2;
    int tmo, lat;
  } row_t;
  row_t rows [4];

  int acc, f0, sc, n;

  initial begin
    rows[0] = '{24'sh300000, 2, -1, 0,        0,        0, 0, 0, 0, 0, 0};
    rows[1] = '{24'sh200000, 2, -1, 'h300000, 0,        2, 0, 3, 0, 0, 0};
    rows[2] = '{24'sh100000, 2,  1, 'h200000, 'h300000, 2, 2, 3, 3, 1, 0};
    rows[3] = '{24'sh7FFFFF, 1, -1, 'h100000, 'h200000, 0, 2, 3, 3, 1, 1};

    rst_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0;
    manual_done = 1'b0; manual_y = '0; model_y = '0; model_done = 1'b0;
    tick(); tick();
    chk("rst_ready", int'(ready_out), 1);
    chk("rst_valid", int'(band_valid_out), 0);
    chk("rst_start", int'(bq_start_out), 0);
    chk("rst_flags", int'({frame_done_out, overrun_out, timeout_out}), 0);
    chk("rst_band_out", int'(band_out), 0);
    rst_in = 1'b1;
    tick();

    // Spurious completion while idle must be ignored
    manual_done = 1'b1; manual_y = 24'sh000123;
    repeat (3) tick();
    manual_done = 1'b0;
    tick();
    chk("spurious_no_valid", q_idx.size(), 0);
    chk("spurious_ready", int'(ready_out), 1);
    chk("spurious_sel", int'(coeff_sel_out), 0);
    chk("spurious_band_out", int'(band_out), 0);

    for (int r = 0; r < 4; r++) begin
      q_idx.delete(); q_val.delete();
      model_delay = rows[r].delay; skip_band = rows[r].skip;
      f0 = frames; stab_err = 0;
      do_frame(rows[r].smp, acc);
      chk_stream("row", rows[r].skip);
      chk("row_frames", frames - f0, 1);
      chk("row_xn", cap_xn[0], int'(rows[r].smp));
      chk("row_xn_b3", cap_xn[3], int'(rows[r].smp));
      chk("row_x1", cap_x1[0], rows[r].x1);
      chk("row_x2", cap_x2[0], rows[r].x2);
      chk("row_b1_y1", cap_y1[1], rows[r].b1y1);
      chk("row_b1_y2", cap_y2[1], rows[r].b1y2);
      chk("row_b2_y1", cap_y1[2], rows[r].b2y1);
      chk("row_b2_y2", cap_y2[2], rows[r].b2y2);
      chk("row_stable", stab_err, 0);
      chk("row_timeout", int'(timeout_out), rows[r].tmo);
      chk("row_overrun", int'(overrun_out), 0);
      if (rows[r].skip >= 0) chk("timeout_latency", to_cyc - start_cyc[rows[r].skip], TO);
      if (rows[r].lat != 0) begin
        chk("lat_start", start_cyc[0] - acc, 1);
        chk("lat_frame_done", done_cyc - acc, 4 * NB);
      end
    end

    // Sample offered mid-frame (during WAIT) is dropped and flagged
    model_delay = 2; skip_band = -1;
    q_idx.delete(); q_val.delete();
    f0 = frames; sc = start_cnt;
    sample_in = 24'sh111111; sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    n = 0;
    while (start_cnt == sc && n < 50) begin tick(); n++; end
    tick();
    sample_in = 24'sh0ABCDE; sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    n = 0;
    while (frames == f0 && n < 300) begin tick(); n++; end
    repeat (30) tick();
    chk("ovr_flag", int'(overrun_out), 1);
    chk_stream("ovr", -1);
    chk("ovr_frames", frames - f0, 1);
    chk("ovr_xn_b3", cap_xn[3], 'h111111);
    chk("ovr_ready", int'(ready_out), 1);

    // Reset during band 2 WAIT aborts the frame and clears history
    f0 = frames; sc = start_cnt;
    sample_in = 24'sh222222; sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    n = 0;
    while (!(start_cnt > sc && last_sel == 2) && n < 100) begin tick(); n++; end
    chk("mid_reached_b2", last_sel, 2);
    tick();
    rst_in = 1'b0;
    #1;
    chk("mid_rst_ready", int'(ready_out), 1);
    chk("mid_rst_valid", int'(band_valid_out), 0);
    chk("mid_rst_flags", int'({frame_done_out, overrun_out, timeout_out}), 0);
    chk("mid_rst_sel", int'(coeff_sel_out), 0);
    chk("mid_rst_xn", int'(bq_x_n_out), 0);
    chk("mid_rst_start", int'(bq_start_out), 0);
    tick();
    rst_in = 1'b1;
    q_idx.delete(); q_val.delete();
    f0 = frames;
    repeat (10) tick();
    chk("mid_no_valid", q_idx.size(), 0);
    chk("mid_no_frame", frames - f0, 0);
    do_frame(24'sh050000, acc);
    chk_stream("post", -1);
    chk("post_xn", cap_xn[0], 'h050000);
    chk("post_x1", cap_x1[0], 0);
    chk("post_x2", cap_x2[0], 0);
    chk("post_b2_y1", cap_y1[2], 0);
    chk("post_b2_y2", cap_y2[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
